// File: rtl/rst_seq.sv
// rst_seq: filters PLL lock and releases per-channel resets one at a time with a programmable stagger
module rst_seq #(
   parameter int CHANNELS    = 2,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_FILTER = 8,
   parameter int STAGGER     = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_locked,
   input  logic                i_sw_rst,
   output logic [CHANNELS-1:0] o_rst,
   output logic                o_ready,
   output logic [7:0]          o_loss_cnt
);
   localparam int FW = LOCK_FILTER > 1 ? $clog2(LOCK_FILTER) : 1;
   localparam int SW = STAGGER > 1 ? $clog2(STAGGER) : 1;
   localparam int IW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   localparam logic [FW-1:0] FC_LAST = FW'(LOCK_FILTER - 1);
   localparam logic [SW-1:0] SC_LAST = SW'(STAGGER - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(CHANNELS - 1);
   typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
   state_t state, state_nx;
   logic [SYNC_STAGES-1:0] sync;
   logic lock_s;
   logic [FW-1:0] fc, fc_nx;
   logic [SW-1:0] sc, sc_nx;
   logic [IW-1:0] idx, idx_nx;
   logic [CHANNELS-1:0] rst_nx;
   logic ready_nx;
   logic [7:0] loss_nx;
   assign lock_s = sync[SYNC_STAGES-1];
   // bring the asynchronous lock indication into the clk domain
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) sync <= '0;
      else sync <= {sync[SYNC_STAGES-2:0], i_locked};
   // state, counters and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state      <= HOLD;
         fc         <= '0;
         sc         <= '0;
         idx        <= '0;
         o_rst      <= '1;
         o_ready    <= 1'b0;
         o_loss_cnt <= '0;
      end else begin
         state      <= state_nx;
         fc         <= fc_nx;
         sc         <= sc_nx;
         idx        <= idx_nx;
         o_rst      <= rst_nx;
         o_ready    <= ready_nx;
         o_loss_cnt <= loss_nx;
      end
   // abort overrides everything; otherwise qualify lock, then release channels in index order
   always_comb begin
      state_nx = state;
      fc_nx    = fc;
      sc_nx    = sc;
      idx_nx   = idx;
      rst_nx   = o_rst;
      ready_nx = o_ready;
      loss_nx  = o_loss_cnt;
      if (!lock_s || i_sw_rst) begin
         state_nx = HOLD;
         fc_nx    = '0;
         sc_nx    = '0;
         idx_nx   = '0;
         rst_nx   = '1;
         ready_nx = 1'b0;
         if (!lock_s && state != HOLD && o_loss_cnt != 8'hff) loss_nx = o_loss_cnt + 8'd1;
      end else begin
         case (state)
            HOLD:
               if (fc == FC_LAST) begin
                  state_nx = RELEASE;
                  fc_nx    = '0;
                  sc_nx    = '0;
                  idx_nx   = '0;
               end else fc_nx = fc + FW'(1);
            RELEASE:
               if (sc == SC_LAST) begin
                  rst_nx = o_rst & ~(CHANNELS'(1) << idx);
                  sc_nx  = '0;
                  idx_nx = idx + IW'(1);
                  if (idx == IDX_LAST) begin
                     state_nx = RUN;
                     ready_nx = 1'b1;
                  end
               end else sc_nx = sc + SW'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed scoreboard bench for rst_seq (default and a 4-channel fast configuration)
module tb_rst_seq;
   logic clk = 1'b0;
   logic i_rst_n, i_locked, i_sw_rst;
   logic [1:0] o_rst;
   logic o_ready;
   logic [7:0] o_loss_cnt;
   logic [3:0] p_rst;
   logic p_ready;
   logic [7:0] p_loss_cnt;
   int passed = 0;
   int total = 0;
   string tags[$];
   logic [31:0] vals[$];

   rst_seq dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_locked(i_locked), .i_sw_rst(i_sw_rst),
      .o_rst(o_rst), .o_ready(o_ready), .o_loss_cnt(o_loss_cnt)
   );

   rst_seq #(.CHANNELS(4), .SYNC_STAGES(3), .LOCK_FILTER(1), .STAGGER(1)) dut_p (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_locked(i_locked), .i_sw_rst(i_sw_rst),
      .o_rst(p_rst), .o_ready(p_ready), .o_loss_cnt(p_loss_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: observed no finish, expected finish within 500000 time units");
      $fatal(1, "timeout");
   end

   function automatic void push(input string t, input logic [31:0] v);
      tags.push_back(t);
      vals.push_back(v);
   endfunction

   task automatic chk(input logic [31:0] obs);
      string t;
      logic [31:0] e;
      total++;
      if (vals.size() == 0) begin
         $error("FAIL scoreboard_empty: observed %0h expected a queued value", obs);
         return;
      end
      t = tags.pop_front();
      e = vals.pop_front();
      assert (obs === e) passed++;
      else $error("FAIL %s: observed %0h expected %0h", t, obs, e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_locked = 1'b0;
      i_sw_rst = 1'b0;
      repeat (5) @(negedge clk);
      push("reset_rst", 2'b11); push("reset_ready", 0); push("reset_loss", 0); push("reset_p_rst", 4'hf);
      chk(o_rst); chk(o_ready); chk(o_loss_cnt); chk(p_rst);
      // power-up: edge 1 is the next posedge
      i_rst_n = 1'b1;
      i_locked = 1'b1;
      push("pu_e25_rst", 2'b11);
      step(25); chk(o_rst);
      push("pu_e26_rst", 2'b10); push("pu_e26_ready", 0);
      step(1); chk(o_rst); chk(o_ready);
      push("pu_e41_rst", 2'b10);
      step(15); chk(o_rst);
      push("pu_e42_rst", 2'b00); push("pu_e42_ready", 1); push("pu_loss", 0);
      step(1); chk(o_rst); chk(o_ready); chk(o_loss_cnt);
      // lock loss in RUN: drop before edge F
      i_locked = 1'b0;
      push("ll_f1_rst", 2'b00); push("ll_f1_ready", 1);
      step(2); chk(o_rst); chk(o_ready);
      push("ll_f2_rst", 2'b11); push("ll_f2_ready", 0); push("ll_f2_loss", 1);
      step(1); chk(o_rst); chk(o_ready); chk(o_loss_cnt);
      // relock repeats the full sequence
      i_locked = 1'b1;
      push("rl_e25_rst", 2'b11);
      step(25); chk(o_rst);
      push("rl_e26_rst", 2'b10);
      step(1); chk(o_rst);
      push("rl_e42_rst", 2'b00); push("rl_e42_ready", 1);
      step(16); chk(o_rst); chk(o_ready);
      // filter glitch: 5 high, 1 low, then high for good
      i_locked = 1'b0;
      step(4);
      i_locked = 1'b1;
      step(5);
      i_locked = 1'b0;
      step(1);
      i_locked = 1'b1;
      push("gl_e25_rst", 2'b11);
      step(25); chk(o_rst);
      push("gl_e26_rst", 2'b10); push("gl_loss", 2);
      step(1); chk(o_rst); chk(o_loss_cnt);
      // software reset between ch0 and ch1 release
      step(4);
      i_sw_rst = 1'b1;
      push("sw_rst", 2'b11); push("sw_ready", 0); push("sw_loss", 2);
      step(1); chk(o_rst); chk(o_ready); chk(o_loss_cnt);
      i_sw_rst = 1'b0;
      push("sw_e23_rst", 2'b11);
      step(23); chk(o_rst);
      push("sw_e24_rst", 2'b10);
      step(1); chk(o_rst);
      // lock loss and software reset on the same edge count as a loss
      i_locked = 1'b0;
      step(2);
      i_sw_rst = 1'b1;
      push("both_rst", 2'b11); push("both_loss", 3);
      step(1); chk(o_rst); chk(o_loss_cnt);
      i_sw_rst = 1'b0;
      i_locked = 1'b1;
      // async reset between edges during RELEASE
      push("ar_pre_rst", 2'b10);
      step(30); chk(o_rst);
      i_rst_n = 1'b0;
      #1;
      push("ar_rst", 2'b11); push("ar_ready", 0); push("ar_loss", 0);
      chk(o_rst); chk(o_ready); chk(o_loss_cnt);
      @(negedge clk);
      i_rst_n = 1'b1;
      // repeated lock loss from RELEASE saturates the counter
      for (int i = 0; i < 300; i++) begin
         i_locked = 1'b1;
         step(11);
         i_locked = 1'b0;
         step(3);
         if (i == 0) begin
            push("sat_first", 1);
            chk(o_loss_cnt);
         end
         if (i == 253) begin
            push("sat_254", 254);
            chk(o_loss_cnt);
         end
         if (i == 254) begin
            push("sat_255", 255);
            chk(o_loss_cnt);
         end
      end
      push("sat_final", 255); push("sat_rst", 2'b11);
      chk(o_loss_cnt); chk(o_rst);
      // fast 4-channel configuration
      i_rst_n = 1'b0;
      step(2);
      i_rst_n = 1'b1;
      i_locked = 1'b1;
      push("p_e4_rst", 4'hf);
      step(4); chk(p_rst);
      push("p_e5_rst", 4'he);
      step(1); chk(p_rst);
      push("p_e6_rst", 4'hc);
      step(1); chk(p_rst);
      push("p_e7_rst", 4'h8); push("p_e7_ready", 0);
      step(1); chk(p_rst); chk(p_ready);
      push("p_e8_rst", 4'h0); push("p_e8_ready", 1); push("p_loss", 0);
      step(1); chk(p_rst); chk(p_ready); chk(p_loss_cnt);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/rst_seq.md
# rst_seq

Parametrised reset sequencer for the SoC clocking subsystem. It replaces the fixed two-flop per-domain reset derivation that follows the PLL. It synchronises and filters the PLL `locked` signal and handles software reset requests. It releases `CHANNELS` active-high reset outputs one at a time in index order, with a programmable stagger, and reasserts all of them when lock is lost. It also counts lock-loss events for debug.

## Interface
- `CHANNELS`, default 2: number of reset outputs, range 1..16.
- `SYNC_STAGES`, default 2: synchroniser depth on `i_locked`, minimum 2.
- `LOCK_FILTER`, default 8: consecutive synchronised-high cycles required before sequencing starts, minimum 1.
- `STAGGER`, default 16: cycles between consecutive channel releases, minimum 1.
- `i_clk`, input, 1: the only clock; all outputs are in this domain.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_locked`, input, 1: PLL lock, asynchronous to `i_clk`.
- `i_sw_rst`, input, 1: synchronous software reset request, level-sensitive.
- `o_rst`, output, `CHANNELS`: per-channel reset, active high.
- `o_ready`, output, 1: high when every channel is released.
- `o_loss_cnt`, output, 8: saturating lock-loss event count.

## Operation
- `i_locked` passes through a `SYNC_STAGES`-flop chain. The last stage is `lock_s`. All logic uses only `lock_s`.
- The FSM has three states: HOLD, RELEASE and RUN.
  - Filter counter `fc` is sized for `LOCK_FILTER`.
  - Stagger counter `sc` is sized for `STAGGER`.
  - Channel index `idx` is sized for `CHANNELS`.
- **HOLD**
  - `o_rst` is all ones and `o_ready` is 0.
  - `fc` increments on each edge where `lock_s` is 1 and `i_sw_rst` is 0. Otherwise `fc` clears to 0.
  - On the edge where `fc` would reach `LOCK_FILTER`, go to RELEASE with `sc`=0, `idx`=0 and `fc`=0.
- **RELEASE**
  - `sc` increments every edge.
  - On the edge where `sc` would reach `STAGGER`: clear `o_rst[idx]`, set `sc` to 0 and increment `idx`.
  - On the same edge, if `idx` was `CHANNELS`-1, go to RUN and set `o_ready` to 1.
- **RUN**
  - `o_rst` is all zeros and `o_ready` is 1.
  - The block holds this state until an abort occurs.
- **Abort**, checked in any state at every edge:
  - Triggered if `lock_s` is 0 or `i_sw_rst` is 1.
  - On that edge: `o_rst` goes to all ones, `o_ready` to 0 and the state to HOLD. `fc`, `sc` and `idx` clear.
  - Abort has priority over any release scheduled on the same edge.
- **Loss counting**
  - `o_loss_cnt` increments by 1 on an abort edge where `lock_s` is 0 and the state is RELEASE or RUN.
  - It saturates at 255.
  - It does not increment for `i_sw_rst`-only aborts or while already in HOLD.
  - If `lock_s` is 0 and `i_sw_rst` is 1 on the same edge, the event counts as a lock loss.
- **Software reset**
  - While `i_sw_rst` is held high, the block stays in HOLD.
  - Sequencing restarts with a full `LOCK_FILTER` qualification after `i_sw_rst` falls.
- **Async reset** (`i_rst_n`=0) takes effect immediately, without waiting for a clock edge:
  - Synchroniser flops go to 0.
  - State goes to HOLD.
  - `fc`, `sc` and `idx` clear.
  - `o_rst` goes to all ones, `o_ready` to 0 and `o_loss_cnt` to 0.
- A reset output never deasserts except through the RELEASE sequence. Every output is a flop with no combinational path from any input.

## Timing
- Edge 1 is the first edge at which `i_locked` is sampled high, with `i_sw_rst` low throughout:
  - `lock_s` rises at edge `SYNC_STAGES`.
  - RELEASE is entered at edge `SYNC_STAGES`+`LOCK_FILTER`.
  - `o_rst[k]` falls at edge `SYNC_STAGES`+`LOCK_FILTER`+(k+1)·`STAGGER`.
  - `o_ready` rises on the same edge as `o_rst[CHANNELS-1]` falls.
  - With defaults: ch0 falls at edge 26; ch1 and `o_ready` change at edge 42.
- Lock-loss latency: if `i_locked` falls before edge F, `o_rst` is all ones at edge F+`SYNC_STAGES`.
- Software reset latency: if `i_sw_rst` is sampled high at edge S, `o_rst` is all ones at edge S.
- Lock glitches:
  - A low pulse on `lock_s` during HOLD restarts `fc` from 0.
  - A high pulse shorter than `LOCK_FILTER` cycles never starts RELEASE.

## Test plan
- **Power-up, defaults:** `i_rst_n` low for 5 cycles; raise `i_locked` before edge 1 → `o_rst`=2'b11 until edge 25; `o_rst`=2'b10 at edge 26; `o_rst`=2'b00 and `o_ready`=1 at edge 42; `o_loss_cnt`=0.
- **Filter glitch:** `i_locked` high for 5 cycles, low for 1, then high → no release until 8 consecutive synchronised-high cycles; ch0 falls 26 edges after the final rise.
- **Lock loss in RUN:** after `o_ready`, drop `i_locked` before edge F → `o_rst`=all ones at edge F+2 and `o_loss_cnt`=1. Relock → full sequence repeats. Repeat 300 times → `o_loss_cnt` saturates at 255.
- **Software reset mid-RELEASE:** assert `i_sw_rst` for 1 cycle after ch0 is released but before ch1 → all ones at that edge; `o_loss_cnt` unchanged; ch0 falls again 8+16 edges later.
- **Async reset mid-sequence:** pull `i_rst_n` low between clock edges in RELEASE → outputs are all ones, `o_ready`=0 and `o_loss_cnt`=0 before the next edge.
- **Parametric:** `CHANNELS`=4, `STAGGER`=1, `LOCK_FILTER`=1, `SYNC_STAGES`=3 → channels fall on consecutive edges 5, 6, 7, 8; `o_ready` rises at edge 8.
